// File: rtl/uart_tx.sv
// 8N1 UART transmitter: sends a DEPTH-byte frame, byte 0 first and each byte LSB first; tx falls 1 cycle after accept.
// A frame is taken only while ready is high; valid while busy is dropped, not queued.
module uart_tx #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int boadrate = 115200,
   parameter int DEPTH    = 4
) (
   input  logic                  clk,
   input  logic                  arstn,
   input  logic [DEPTH-1:0][7:0] data,
   input  logic                  valid,
   output logic                  ready,
   output logic                  tx,
   output logic                  done
);

   localparam int CLKS_PER_BIT = CLK_FREQ / boadrate;
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DEPTH - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic [1:0]         state;
   logic [CW-1:0]      cnt;
   logic [2:0]         bit_idx;
   logic [IW-1:0]      byte_idx;
   logic [DEPTH*8-1:0] shreg;

   // The shift register is consumed from bit 0, so byte 0 LSB leaves first and
   // each following byte slides down into the low bits as the frame proceeds.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         shreg    <= '0;
         tx       <= 1'b1;
         ready    <= 1'b1;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (valid) begin
                  shreg    <= data;
                  byte_idx <= '0;
                  cnt      <= '0;
                  state    <= START;
                  ready    <= 1'b0;
                  tx       <= 1'b0;
               end
            end
            START: begin
               if (cnt == CNT_LAST) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= DATA;
                  tx      <= shreg[0];
                  shreg   <= shreg >> 1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                     tx    <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= shreg[0];
                     shreg   <= shreg >> 1;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            STOP: begin
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (byte_idx != IDX_LAST) begin
                     byte_idx <= byte_idx + IW'(1);
                     state    <= START;
                     tx       <= 1'b0;
                  end else begin
                     state <= IDLE;
                     ready <= 1'b1;
                     done  <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART 8N1 transmitter that pairs with uart_rx.
- Accepts a packed frame of DEPTH bytes through a valid/ready handshake.
- Serialises the bytes on tx: byte 0 first, each byte LSB first.
- Sits between the core data path and the board UART pin; its output is directly consumable by uart_rx with the same boadrate and DEPTH.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- boadrate, 115200, serial bit rate in bit/s.
- DEPTH, 4, number of bytes per transmitted frame (>=1).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- arstn  input  1  asynchronous active-low reset.
- data  input  [DEPTH-1:0][7:0]  frame to send; data[0] goes out first.
- valid  input  1  frame request; a transfer occurs on a clk edge where valid && ready.
- ready  output  1  high when idle and able to accept a frame.
- tx  output  1  serial line; idles high.
- done  output  1  one-cycle pulse when the last stop bit of a frame completes.

Behaviour:
- Clock and reset: one clock, clk. Reset arstn is asynchronous, active-low.
- Reset values (while arstn=0, applied asynchronously): tx=1, ready=1, done=0, state=IDLE, all counters=0.
- Bit period: CLKS_PER_BIT = CLK_FREQ/boadrate, integer truncation (434 at defaults).
  - Baud counter width is $clog2(CLKS_PER_BIT).
  - Every start, data and stop bit lasts exactly CLKS_PER_BIT clk cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- State machine: IDLE, START, DATA, STOP.
  - IDLE:
    - ready=1, tx=1.
    - On valid=1, latch all of data into a DEPTH*8-bit shift register, clear the byte index, go to START, and drop ready the same edge.
    - tx goes low in the first cycle after the handshake edge (latency 1).
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA:
    - tx = current byte bit[idx], LSB first, each bit for CLKS_PER_BIT cycles.
    - After bit 7, go to STOP.
  - STOP:
    - tx=1 for CLKS_PER_BIT cycles.
    - If the byte index < DEPTH-1, increment it and go to START immediately. There is no extra idle between bytes of one frame.
    - Otherwise go to IDLE, with ready=1 and done=1 in that first IDLE cycle.
- Frame duration: the first start bit to the end of the last stop bit is DEPTH*10*CLKS_PER_BIT cycles (17360 at defaults).
- done is high for exactly one cycle per frame. done=1 coincides with ready=1.
- Back-to-back frames:
  - If valid is high in the cycle done=1, the new frame is accepted on that edge.
  - The minimum line-high gap between frames is CLKS_PER_BIT+1 cycles.
- Inputs while busy:
  - valid while ready=0 is ignored and is not queued.
  - Changes on data after the handshake have no effect on the frame in flight.
- Reset mid-frame: tx returns to 1 immediately (asynchronously). The frame is discarded. After reset release the block sits in IDLE with ready=1, and there is no resumption.
- DEPTH=1: behaves as a single-byte transmitter; done follows each byte.

Test Plan:
- Reset: hold arstn=0 for 3 clk, change valid/data freely -> tx=1, ready=1, done=0 throughout; asserting arstn=0 mid-frame forces tx=1 within the same cycle.
- Single frame, data = {0xF0,0xF0,0xF0,0x55} (data[0]=0x55):
  - Pulse valid for 1 cycle -> tx low 1 cycle later.
  - Sampling at bit centres gives 0,1,0,1,0,1,0,1,0,1 (start, 0x55 LSB first, stop) then 0,0,0,0,0,1,1,1,1,1 ×3.
  - Each bit is 434 cycles; done pulses once, 17360 cycles after the start-bit edge; ready is low the whole time.
- Loopback: tx wired to a uart_rx instance (boadrate 115200, DEPTH 4), sending 0xA5,0x3C,0x00,0xFF -> the receiver's valid pulses once and its data equals the sent frame.
- Busy rejection:
  - During the frame, pulse valid with different data three times -> the waveform is unchanged and exactly one done pulse occurs.
  - Changing data mid-frame -> no effect.
- Back-to-back: hold valid=1 continuously with two frames -> the second start bit begins exactly CLKS_PER_BIT+1 cycles after the first frame's last stop-bit start edge. Both frames are decoded correctly by uart_rx.
- Parameter sweep: DEPTH=1 and CLK_FREQ/boadrate = 16 -> bit period 16 cycles, frame 160 cycles, done once per byte.
